cpu_ce_gen: RTL

- Parametrised successor to the top-level CPU/PSG clock-enable generator; produces the CPU phase enables for the T80 core.
- Generalises the fixed two-speed scheme (native ASIC timing vs. ZX-speed timing) to NMODES selectable CPU speeds, each with its own divider period.
- Adds per-mode contention-wait gating, glitch-free mode switching with a programmable dead gap, and an independent fixed-rate auxiliary enable for sound chips.
- Sits between clk_sys and the CPU CEN_p/CEN_n inputs.

---
 rtl/cpu_ce_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cpu_ce_gen.sv
// CPU phase-enable generator: NMODES selectable divider periods, per-mode contention
// wait gating, glitch-free mode switching with an idle gap, and a fixed-rate aux enable.
module cpu_ce_gen #(
  parameter int                       NMODES      = 2,
  parameter int                       CNT_W       = 6,
  parameter logic [NMODES*CNT_W-1:0]  PERIODS     = {6'd27, 6'd16},
  parameter logic [NMODES-1:0]        NOWAIT_MASK = 2'b10,
  parameter int                       GAP         = 3,
  parameter int                       AUX_DIV     = 12,
  localparam int                      MW          = (NMODES > 1) ? $clog2(NMODES) : 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [MW-1:0] mode_req,
  input  logic          wait_req,
  input  logic          wait_dis,
  output logic          ce_p,
  output logic          ce_n,
  output logic          ce_aux,
  output logic [MW-1:0] mode_cur,
  output logic          switching,
  output logic          waiting
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       gcnt;
  logic [7:0]       aux_cnt;

  logic [CNT_W-1:0] period_tab [NMODES];
  logic [CNT_W-1:0] p;
  logic             at_zero;
  logic             at_half;
  logic             at_last;
  logic             gate_new;
  logic             gated;

  for (genvar m = 0; m < NMODES; m++) begin : g_tab
    assign period_tab[m] = PERIODS[m*CNT_W +: CNT_W];
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    p        = period_tab[mode_cur];
    at_zero  = (cnt == '0);
    at_half  = (cnt == (p >> 1));
    at_last  = (cnt == p - 1'b1);
    gate_new = wait_req & ~wait_dis & ~NOWAIT_MASK[mode_cur];
    // The gate decided at period start already applies to that period's ce_p.
    gated    = at_zero ? gate_new : waiting;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_RUN;
      cnt       <= '0;
      gcnt      <= '0;
      mode_cur  <= mode_req;
      ce_p      <= 1'b0;
      ce_n      <= 1'b0;
      switching <= 1'b0;
      waiting   <= 1'b0;
    end else begin
      ce_p <= 1'b0;
      ce_n <= 1'b0;
      cnt  <= at_last ? '0 : cnt + 1'b1;
      unique case (state)
        S_RUN: begin
          if (at_zero) waiting <= gate_new;
          ce_p <= at_zero & ~gated;
          ce_n <= at_half & ~gated;
          if (mode_req != mode_cur) begin
            state   <= S_DRAIN;
            waiting <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Let the running period finish so no pulse is truncated.
          ce_p <= at_zero;
          ce_n <= at_half;
          if (at_last) begin
            state     <= S_GAP;
            switching <= 1'b1;
            gcnt      <= 4'(GAP);
          end
        end
        S_GAP: begin
          if (at_last) begin
            gcnt <= gcnt - 1'b1;
            if (gcnt == 4'd1) begin
              state     <= S_RUN;
              switching <= 1'b0;
              mode_cur  <= mode_req;
            end
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Aux divider is independent of mode, wait and switching.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      aux_cnt <= '0;
      ce_aux  <= 1'b0;
    end else begin
      ce_aux  <= (aux_cnt == '0);
      aux_cnt <= (aux_cnt == 8'(AUX_DIV - 1)) ? '0 : aux_cnt + 1'b1;
    end
  end

endmodule
